simon_seq_engine: RTL and testbench
===================================

Name: simon_seq_engine

Overview:
- Parametrised successor to the game's LIFO note store: an append-only sequence memory with timed playback and in-order player checking.
- Sits between the player input pins and the tone oscillator. Drives NOTE/NOTE_VALID into the oscillator note select.
- Reports round outcome (MATCH_ALL / MISMATCH) to the game controller.

Parameters:
- DATA_WIDTH, 2, bits per note (2^DATA_WIDTH distinct notes).
- DEPTH, 16, maximum sequence length; any integer >= 2, not required to be a power of two.
- STEP_CYCLES, 25_000_000, clock cycles each note is held during playback; >= 1.
- GAP_CYCLES, 5_000_000, silent cycles after each played note; >= 1.
- Derived widths use the codebase clog2 function: IDX_W = clog2(DEPTH), LVL_W = clog2(DEPTH+1), CNT_W = clog2(max(STEP_CYCLES, GAP_CYCLES)+1).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- PUSH  in  1  append DATA_IN to sequence (1-cycle strobe)
- DATA_IN  in  DATA_WIDTH  note to append
- CLEAR  in  1  empty the sequence, abort any activity
- START_PLAY  in  1  begin playback from index 0
- START_CHECK  in  1  begin checking player guesses from index 0
- GUESS_VALID  in  1  GUESS is valid this cycle
- GUESS  in  DATA_WIDTH  player's note
- NOTE  out  DATA_WIDTH  note being played; 0 when NOTE_VALID=0
- NOTE_VALID  out  1  high during a note hold
- PLAY_DONE  out  1  1-cycle pulse when playback finishes
- MATCH_ALL  out  1  1-cycle pulse when the whole sequence is guessed correctly
- MISMATCH  out  1  1-cycle pulse on a wrong guess
- LEVEL  out  LVL_W  number of stored notes
- FULL  out  1  LEVEL == DEPTH
- EMPTY  out  1  LEVEL == 0
- BUSY  out  1  state != IDLE

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; LEVEL=0; idx=0; counter=0.
  - All pulse outputs 0; NOTE=0; NOTE_VALID=0; EMPTY=1; FULL=0; BUSY=0.
  - Memory contents are don't-care.
- All outputs are registered; pulse outputs are high for exactly one cycle.
- States: IDLE, PLAY_NOTE, PLAY_GAP, CHECK.
- IDLE command priority is CLEAR > START_PLAY > START_CHECK > PUSH; only the highest-priority asserted command acts.
  - CLEAR: LEVEL<=0.
  - START_PLAY:
    - EMPTY: PLAY_DONE pulses next cycle, stay IDLE.
    - Otherwise: idx<=0, counter<=STEP_CYCLES-1, go to PLAY_NOTE.
  - START_CHECK:
    - EMPTY: MATCH_ALL pulses next cycle, stay IDLE.
    - Otherwise: idx<=0, go to CHECK.
  - PUSH:
    - Not FULL: mem[LEVEL]<=DATA_IN, LEVEL+1.
    - FULL: ignored, no state change.
- PLAY_NOTE:
  - NOTE=mem[idx], NOTE_VALID=1. Counter decrements each cycle.
  - At 0: counter<=GAP_CYCLES-1, go to PLAY_GAP.
  - Each note therefore holds exactly STEP_CYCLES cycles.
- PLAY_GAP:
  - NOTE_VALID=0, NOTE=0. Lasts exactly GAP_CYCLES cycles.
  - At 0, if idx==LEVEL-1: PLAY_DONE pulse, go to IDLE.
  - Otherwise: idx+1, counter<=STEP_CYCLES-1, go to PLAY_NOTE.
- CHECK: on GUESS_VALID, compare GUESS to mem[idx].
  - Unequal: MISMATCH pulse, go to IDLE.
  - Equal and idx==LEVEL-1: MATCH_ALL pulse, go to IDLE.
  - Equal otherwise: idx+1, stay in CHECK.
  - No timeout; the game controller owns timeouts.
- While BUSY: PUSH, START_PLAY and START_CHECK are ignored.
- CLEAR while BUSY:
  - Next cycle: state IDLE, LEVEL=0, NOTE_VALID=0.
  - No PLAY_DONE, MATCH_ALL or MISMATCH pulse.
- Reset mid-operation returns immediately to the reset values above.
- GUESS_VALID in IDLE is ignored.
- idx never exceeds LEVEL-1; LEVEL never exceeds DEPTH.

Optional Feature:
- Macro SIMON_SEQ_RANDOM_EN.
- When defined:
  - Adds a 16-bit Galois LFSR (taps 16,14,13,11), seed 16'hACE1 at reset, advancing every cycle.
  - PUSH appends the LFSR's low DATA_WIDTH bits; DATA_IN is ignored.
- When undefined: no LFSR logic; PUSH appends DATA_IN.

Test Plan (DEPTH=4, STEP_CYCLES=3, GAP_CYCLES=2, DATA_WIDTH=2, macro undefined):
- Reset, then PUSH 2,1,3 -> LEVEL=3, EMPTY=0, FULL=0. PUSH 0 -> FULL=1. PUSH 1 while FULL -> LEVEL stays 4.
- Sequence 2,1,3; START_PLAY -> NOTE_VALID/NOTE pattern 2,2,2 then gap x2, 1,1,1 then gap x2, 3,3,3 then gap x2; PLAY_DONE pulses 1 cycle; BUSY high for 15 cycles.
- Sequence 2,1,3; START_CHECK; guesses 2,1,3 -> MATCH_ALL pulse after third guess, no MISMATCH.
- Sequence 2,1,3; START_CHECK; guesses 2,0 -> MISMATCH pulse on second guess, state IDLE, LEVEL still 3.
- During PLAY_NOTE assert CLEAR -> next cycle BUSY=0, NOTE_VALID=0, LEVEL=0, no PLAY_DONE. START_PLAY on empty -> immediate PLAY_DONE pulse.
- IDLE, CLEAR+START_PLAY+PUSH in the same cycle -> only CLEAR acts. Deassert RST_N mid-CHECK -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/simon_seq_engine.sv
// rtl/simon_seq_engine.sv - append-only note sequence store with timed playback and in-order guess checking
// Optional build macro: SIMON_SEQ_RANDOM_EN (PUSH appends LFSR bits instead of i_data_in)
module simon_seq_engine #(
  parameter int DATA_WIDTH  = 2,
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int LVL_W       = $clog2(DEPTH + 1),
  parameter int CNT_W       = $clog2(((STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_clear,
  input  logic                  i_start_play,
  input  logic                  i_start_check,
  input  logic                  i_guess_valid,
  input  logic [DATA_WIDTH-1:0] i_guess,
  output logic [DATA_WIDTH-1:0] o_note,
  output logic                  o_note_valid,
  output logic                  o_play_done,
  output logic                  o_match_all,
  output logic                  o_mismatch,
  output logic [LVL_W-1:0]      o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY_NOTE = 2'd1,
    PLAY_GAP  = 2'd2,
    CHECK     = 2'd3
  } state_t;

  state_t                r_state, w_state_nx;
  logic [LVL_W-1:0]      r_level, w_level_nx;
  logic [IDX_W-1:0]      r_idx, w_idx_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0] r_note, w_note_nx;
  logic                  r_note_valid, w_note_valid_nx;
  logic                  r_play_done, w_play_done_nx;
  logic                  r_match_all, w_match_all_nx;
  logic                  r_mismatch, w_mismatch_nx;
  logic                  r_busy, r_full, r_empty;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]      w_idx_inc;
  logic                  w_last;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_last    = (LVL_W'(r_idx) == (r_level - LVL_W'(1)));

`ifdef SIMON_SEQ_RANDOM_EN
  logic [15:0] r_lfsr;
  logic        w_unused_data;
  assign w_unused_data = ^i_data_in;
  assign w_push_data   = r_lfsr[DATA_WIDTH-1:0];

  // Galois LFSR (taps 16,14,13,11) free-running as the random note source
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end
`else
  assign w_push_data = i_data_in;
`endif

  // Sequence storage; contents are meaningless beyond r_level so no reset
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_level[IDX_W-1:0]] <= w_push_data;
  end

  // Next-state and next-output logic; outputs are computed here and registered below
  always_comb begin
    w_state_nx      = r_state;
    w_level_nx      = r_level;
    w_idx_nx        = r_idx;
    w_cnt_nx        = r_cnt;
    w_note_nx       = '0;
    w_note_valid_nx = 1'b0;
    w_play_done_nx  = 1'b0;
    w_match_all_nx  = 1'b0;
    w_mismatch_nx   = 1'b0;
    w_wr_en         = 1'b0;
    if (i_clear) begin
      // CLEAR wins in every state and suppresses any completion pulse
      w_state_nx = IDLE;
      w_level_nx = '0;
      w_idx_nx   = '0;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_play) begin
            if (r_empty) begin
              w_play_done_nx = 1'b1;
            end else begin
              w_idx_nx        = '0;
              w_cnt_nx        = CNT_W'(STEP_CYCLES - 1);
              w_state_nx      = PLAY_NOTE;
              w_note_nx       = r_mem[0];
              w_note_valid_nx = 1'b1;
            end
          end else if (i_start_check) begin
            if (r_empty) begin
              w_match_all_nx = 1'b1;
            end else begin
              w_idx_nx   = '0;
              w_state_nx = CHECK;
            end
          end else if (i_push && !r_full) begin
            w_wr_en    = 1'b1;
            w_level_nx = r_level + LVL_W'(1);
          end
        end
        PLAY_NOTE: begin
          w_note_nx       = r_mem[r_idx];
          w_note_valid_nx = 1'b1;
          if (r_cnt == '0) begin
            w_cnt_nx        = CNT_W'(GAP_CYCLES - 1);
            w_state_nx      = PLAY_GAP;
            w_note_nx       = '0;
            w_note_valid_nx = 1'b0;
          end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end
        end
        PLAY_GAP: begin
          if (r_cnt == '0) begin
            if (w_last) begin
              w_play_done_nx = 1'b1;
              w_state_nx     = IDLE;
            end else begin
              w_idx_nx        = w_idx_inc;
              w_cnt_nx        = CNT_W'(STEP_CYCLES - 1);
              w_state_nx      = PLAY_NOTE;
              w_note_nx       = r_mem[w_idx_inc];
              w_note_valid_nx = 1'b1;
            end
          end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end
        end
        CHECK: begin
          if (i_guess_valid) begin
            if (i_guess != r_mem[r_idx]) begin
              w_mismatch_nx = 1'b1;
              w_state_nx    = IDLE;
            end else if (w_last) begin
              w_match_all_nx = 1'b1;
              w_state_nx     = IDLE;
            end else begin
              w_idx_nx = w_idx_inc;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_level      <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_note       <= '0;
      r_note_valid <= 1'b0;
      r_play_done  <= 1'b0;
      r_match_all  <= 1'b0;
      r_mismatch   <= 1'b0;
      r_busy       <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_level      <= w_level_nx;
      r_idx        <= w_idx_nx;
      r_cnt        <= w_cnt_nx;
      r_note       <= w_note_nx;
      r_note_valid <= w_note_valid_nx;
      r_play_done  <= w_play_done_nx;
      r_match_all  <= w_match_all_nx;
      r_mismatch   <= w_mismatch_nx;
      r_busy       <= (w_state_nx != IDLE);
      r_full       <= (w_level_nx == LVL_W'(DEPTH));
      r_empty      <= (w_level_nx == '0);
    end
  end

  assign o_note       = r_note;
  assign o_note_valid = r_note_valid;
  assign o_play_done  = r_play_done;
  assign o_match_all  = r_match_all;
  assign o_mismatch   = r_mismatch;
  assign o_level      = r_level;
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_simon_seq_engine.sv
// tb/tb_simon_seq_engine.sv - scoreboard bench for simon_seq_engine
module tb_simon_seq_engine;
  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int STEP  = 3;
  localparam int GAP   = 2;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0, clear = 1'b0, start_play = 1'b0, start_check = 1'b0, guess_valid = 1'b0;
  logic [DW-1:0] data_in = '0, guess = '0;
  logic [DW-1:0] note;
  logic          note_valid, play_done, match_all, mismatch, full, empty, busy;
  logic [LVL_W-1:0] level;

  int         checks = 0;
  int         errors = 0;
  int         model[$];
  logic [6:0] exp_q[$];

  simon_seq_engine #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .STEP_CYCLES(STEP), .GAP_CYCLES(GAP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_data_in(data_in),
    .i_clear(clear), .i_start_play(start_play), .i_start_check(start_check),
    .i_guess_valid(guess_valid), .i_guess(guess),
    .o_note(note), .o_note_valid(note_valid), .o_play_done(play_done),
    .o_match_all(match_all), .o_mismatch(mismatch), .o_level(level),
    .o_full(full), .o_empty(empty), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {busy, note_valid, note, play_done, match_all, mismatch}
  function automatic logic [6:0] obs_vec();
    return {busy, note_valid, note, play_done, match_all, mismatch};
  endfunction

  function automatic logic [6:0] ev(input logic b, input logic v, input int n,
                                    input logic d, input logic m, input logic x);
    logic [DW-1:0] nn;
    nn = DW'(n);
    return {b, v, nn, d, m, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_sb(input string tag);
    tick();
    check_eq(tag, {25'd0, obs_vec()}, {25'd0, exp_q.pop_front()});
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick_sb(tag);
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_level"}, 32'(level), 32'(model.size()));
    check_eq({tag, "_full"},  32'(full),  32'(model.size() == DEPTH));
    check_eq({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
  endtask

  task automatic push_note(input int d);
    push = 1'b1; data_in = DW'(d);
    tick();
    push = 1'b0;
    if (model.size() < DEPTH) model.push_back(d);
    check_flags("push");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model.delete();
    check_flags("clear");
  endtask

  task automatic run_play();
    if (model.size() == 0) begin
      exp_q.push_back(ev(0, 0, 0, 1, 0, 0));
    end else begin
      foreach (model[i]) begin
        for (int s = 0; s < STEP; s++) exp_q.push_back(ev(1, 1, model[i], 0, 0, 0));
        for (int s = 0; s < GAP; s++)  exp_q.push_back(ev(1, 0, 0, 0, 0, 0));
      end
      exp_q.push_back(ev(0, 0, 0, 1, 0, 0));
    end
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    start_play = 1'b1;
    tick_sb("play");
    start_play = 1'b0;
    drain("play");
  endtask

  task automatic run_check(input int n, input int gs[4]);
    bit fin;
    start_check = 1'b1;
    if (model.size() == 0) begin
      exp_q.push_back(ev(0, 0, 0, 0, 1, 0));
      tick_sb("chk_start");
      start_check = 1'b0;
    end else begin
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0));
      tick_sb("chk_start");
      start_check = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < n && !fin; i++) begin
        guess_valid = 1'b1; guess = DW'(gs[i]);
        if (gs[i] != model[i]) begin
          exp_q.push_back(ev(0, 0, 0, 0, 0, 1)); fin = 1'b1;
        end else if (i == model.size() - 1) begin
          exp_q.push_back(ev(0, 0, 0, 0, 1, 0)); fin = 1'b1;
        end else begin
          exp_q.push_back(ev(1, 0, 0, 0, 0, 0));
        end
        tick_sb("chk_guess");
        guess_valid = 1'b0;
      end
    end
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    drain("chk_end");
  endtask

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    check_eq("rst_vec", {25'd0, obs_vec()}, 32'd0);
    check_flags("rst");
    rst_n = 1'b1;
    tick();

    push_note(2); push_note(1); push_note(3);
    push_note(0);
    push_note(1);

    do_clear();
    push_note(2); push_note(1); push_note(3);
    run_play();
    run_check(3, '{2, 1, 3, 0});
    run_check(2, '{2, 0, 0, 0});
    check_flags("after_mis");

    start_play = 1'b1; tick(); start_play = 1'b0; tick();
    clear = 1'b1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    tick_sb("clr_play");
    clear = 1'b0;
    model.delete();
    check_flags("clr_play");
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    drain("clr_quiet");
    run_play();
    run_check(1, '{0, 0, 0, 0});

    push_note(1); push_note(2);
    clear = 1'b1; start_play = 1'b1; push = 1'b1; data_in = 2'd3;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    tick_sb("prio");
    clear = 1'b0; start_play = 1'b0; push = 1'b0;
    model.delete();
    check_flags("prio");
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    tick_sb("prio_after");
    check_flags("prio_after");

    push_note(2); push_note(1); push_note(3);
    start_check = 1'b1; tick(); start_check = 1'b0;
    check_eq("in_check_busy", 32'(busy), 32'd1);
    guess_valid = 1'b1; guess = 2'd2; tick(); guess_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model.delete();
    check_eq("async_rst_vec", {25'd0, obs_vec()}, 32'd0);
    check_flags("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_flags("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
